// File: rtl/mcs8_pkg.sv
// Shared encodings for the MCS-8 bus controller: CPU state codes, bus cycle
// types and the controller FSM states.
package mcs8_pkg;

  typedef enum logic [2:0] {
    ST_WAIT = 3'b000,
    ST_T3   = 3'b001,
    ST_T1   = 3'b010,
    ST_STOP = 3'b011,
    ST_T2   = 3'b100,
    ST_T5   = 3'b101,
    ST_T1I  = 3'b110,
    ST_T4   = 3'b111
  } cpu_state_e;

  typedef enum logic [1:0] {
    CYC_PCI = 2'b00,
    CYC_PCC = 2'b01,
    CYC_PCR = 2'b10,
    CYC_PCW = 2'b11
  } cyc_type_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_L,
    S_DECODE,
    S_WAIT_T3,
    S_ACCESS,
    S_HOLD
  } bus_state_e;

  function automatic logic is_t1(input cpu_state_e s);
    return (s == ST_T1) || (s == ST_T1I);
  endfunction

endpackage

// File: rtl/mcs8_bus_timer.sv
// Access watchdog: counts cycles while enabled and flags the cycle in which
// the count is about to reach TIMEOUT.
module mcs8_bus_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mcs8_bus_ctrl.sv
// MCS-8 CPU bus controller: decodes T1/T2/T3 state strobes into memory and
// I/O accesses, handles READY, interrupt jamming and access timeout.
module mcs8_bus_ctrl
  import mcs8_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK_I,
  input  logic        nRST_I,
  input  logic        SYNC_I,
  input  logic [2:0]  STATE_I,
  input  logic [7:0]  CPU_DAT_I,
  output logic [7:0]  CPU_DAT_O,
  output logic        READY_O,
  input  logic        INT_REQ_I,
  input  logic [7:0]  INT_VEC_I,
  output logic        INT_O,
  output logic [13:0] MEM_ADDR_O,
  output logic [7:0]  MEM_DAT_O,
  input  logic [7:0]  MEM_DAT_I,
  output logic        MEM_RD_O,
  output logic        MEM_WR_O,
  input  logic        MEM_ACK_I,
  output logic [4:0]  IO_PORT_O,
  output logic [7:0]  IO_DAT_O,
  input  logic [7:0]  IO_DAT_I,
  output logic        IO_RD_O,
  output logic        IO_WR_O,
  input  logic        IO_ACK_I,
  output logic        ERR_O
);

  bus_state_e  state, state_d;
  cyc_type_e   cyc, cyc_d;
  cpu_state_e  cpu_st;
  logic        sync_q, strobe, ack, expired;
  logic [7:0]  addr_l, addr_l_d, cpu_dat, cpu_dat_d, mem_dat, mem_dat_d, io_dat, io_dat_d;
  logic [13:0] mem_addr, mem_addr_d;
  logic [4:0]  io_port, io_port_d;
  logic        ack_flag, ack_flag_d, ready, ready_d, err, err_d;
  logic        mem_rd, mem_rd_d, mem_wr, mem_wr_d, io_rd, io_rd_d, io_wr, io_wr_d;
  logic        int_o, int_d, int_pend, int_pend_d;

  assign cpu_st = cpu_state_e'(STATE_I);
  assign strobe = SYNC_I && !sync_q;
  assign ack    = (mem_rd || mem_wr) ? MEM_ACK_I : IO_ACK_I;

  mcs8_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (CLK_I),
    .rst_n   (nRST_I),
    .clear   (state != S_ACCESS),
    .enable  (state == S_ACCESS),
    .expired (expired)
  );

  always_ff @(posedge CLK_I or negedge nRST_I) begin
    if (!nRST_I) begin
      state    <= S_IDLE;
      cyc      <= CYC_PCI;
      sync_q   <= 1'b0;
      addr_l   <= '0;
      mem_addr <= '0;
      cpu_dat  <= '0;
      mem_dat  <= '0;
      io_dat   <= '0;
      io_port  <= '0;
      ack_flag <= 1'b0;
      ready    <= 1'b1;
      err      <= 1'b0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      io_rd    <= 1'b0;
      io_wr    <= 1'b0;
      int_o    <= 1'b0;
      int_pend <= 1'b0;
    end else begin
      state    <= state_d;
      cyc      <= cyc_d;
      sync_q   <= SYNC_I;
      addr_l   <= addr_l_d;
      mem_addr <= mem_addr_d;
      cpu_dat  <= cpu_dat_d;
      mem_dat  <= mem_dat_d;
      io_dat   <= io_dat_d;
      io_port  <= io_port_d;
      ack_flag <= ack_flag_d;
      ready    <= ready_d;
      err      <= err_d;
      mem_rd   <= mem_rd_d;
      mem_wr   <= mem_wr_d;
      io_rd    <= io_rd_d;
      io_wr    <= io_wr_d;
      int_o    <= int_d;
      int_pend <= int_pend_d;
    end
  end

  always_comb begin
    state_d    = state;
    cyc_d      = cyc;
    addr_l_d   = addr_l;
    mem_addr_d = mem_addr;
    cpu_dat_d  = cpu_dat;
    mem_dat_d  = mem_dat;
    io_dat_d   = io_dat;
    io_port_d  = io_port;
    ack_flag_d = ack_flag;
    ready_d    = ready;
    err_d      = 1'b0;
    mem_rd_d   = mem_rd;
    mem_wr_d   = mem_wr;
    io_rd_d    = io_rd;
    io_wr_d    = io_wr;
    int_d      = int_o;
    int_pend_d = int_pend;

    if (strobe && cpu_st == ST_STOP) begin
      {mem_rd_d, mem_wr_d, io_rd_d, io_wr_d} = '0;
      ready_d = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_HOLD: begin
          if (strobe && is_t1(cpu_st)) begin
            addr_l_d   = CPU_DAT_I;
            ack_flag_d = (cpu_st == ST_T1I);
            state_d    = S_ADDR_L;
          end
        end
        S_ADDR_L: begin
          if (strobe && cpu_st == ST_T2) begin
            mem_addr_d = {CPU_DAT_I[5:0], addr_l};
            cyc_d      = cyc_type_e'(CPU_DAT_I[7:6]);
            ready_d    = 1'b0;
            state_d    = S_DECODE;
          end
        end
        S_DECODE: begin
          case (cyc)
            CYC_PCI, CYC_PCR: begin
              if (ack_flag) begin
                // Interrupt acknowledge: jam the vector, no memory access.
                cpu_dat_d = INT_VEC_I;
                ready_d   = 1'b1;
                state_d   = S_HOLD;
              end else begin
                mem_rd_d = 1'b1;
                state_d  = S_ACCESS;
              end
            end
            CYC_PCW: state_d = S_WAIT_T3;
            CYC_PCC: begin
              io_port_d = mem_addr[13:9];
              if (mem_addr[13:12] == 2'b00) io_rd_d = 1'b1;
              else begin
                io_dat_d = addr_l;
                io_wr_d  = 1'b1;
              end
              state_d = S_ACCESS;
            end
            default: state_d = S_IDLE;
          endcase
        end
        S_WAIT_T3: begin
          if (strobe && (cpu_st == ST_T3 || cpu_st == ST_WAIT)) begin
            mem_dat_d = CPU_DAT_I;
            mem_wr_d  = 1'b1;
            state_d   = S_ACCESS;
          end
        end
        S_ACCESS: begin
          // An acknowledge wins over a simultaneous timer expiry.
          if (ack || expired) begin
            {mem_rd_d, mem_wr_d, io_rd_d, io_wr_d} = '0;
            if (ack) begin
              if (mem_rd)     cpu_dat_d = MEM_DAT_I;
              else if (io_rd) cpu_dat_d = IO_DAT_I;
            end else begin
              if (mem_rd || io_rd) cpu_dat_d = 8'hFF;
              err_d = 1'b1;
            end
            ready_d = 1'b1;
            state_d = S_HOLD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (strobe && cpu_st == ST_T1I) begin
      int_d      = 1'b0;
      int_pend_d = 1'b0;
    end else if (state == S_IDLE || state == S_HOLD) begin
      if (INT_REQ_I || int_pend) begin
        int_d      = 1'b1;
        int_pend_d = 1'b0;
      end
    end else if (INT_REQ_I) begin
      int_pend_d = 1'b1;
    end
  end

  assign CPU_DAT_O  = cpu_dat;
  assign READY_O    = ready;
  assign INT_O      = int_o;
  assign MEM_ADDR_O = mem_addr;
  assign MEM_DAT_O  = mem_dat;
  assign MEM_RD_O   = mem_rd;
  assign MEM_WR_O   = mem_wr;
  assign IO_PORT_O  = io_port;
  assign IO_DAT_O   = io_dat;
  assign IO_RD_O    = io_rd;
  assign IO_WR_O    = io_wr;
  assign ERR_O      = err;

endmodule

// File: tb/tb_mcs8_bus_ctrl.sv
// Directed bench for mcs8_bus_ctrl: read, write, OUT/INP, interrupt jam,
// timeout, ack-versus-expiry and asynchronous reset.
module tb_mcs8_bus_ctrl;
  localparam int TIMEOUT = 8;
  localparam logic [2:0] T1 = 3'b010, T2 = 3'b100, T3 = 3'b001, T1I = 3'b110, STOP = 3'b011;

  logic        CLK_I = 1'b0, nRST_I, SYNC_I;
  logic [2:0]  STATE_I;
  logic [7:0]  CPU_DAT_I, CPU_DAT_O, INT_VEC_I, MEM_DAT_O, MEM_DAT_I, IO_DAT_O, IO_DAT_I;
  logic        READY_O, INT_REQ_I, INT_O, MEM_RD_O, MEM_WR_O, MEM_ACK_I;
  logic        IO_RD_O, IO_WR_O, IO_ACK_I, ERR_O;
  logic [13:0] MEM_ADDR_O;
  logic [4:0]  IO_PORT_O;

  int errors = 0, checks = 0;
  int rd_rises = 0, err_rises = 0, excl = 0;
  int rd0;

  mcs8_bus_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .CLK_I(CLK_I), .nRST_I(nRST_I), .SYNC_I(SYNC_I), .STATE_I(STATE_I),
    .CPU_DAT_I(CPU_DAT_I), .CPU_DAT_O(CPU_DAT_O), .READY_O(READY_O),
    .INT_REQ_I(INT_REQ_I), .INT_VEC_I(INT_VEC_I), .INT_O(INT_O),
    .MEM_ADDR_O(MEM_ADDR_O), .MEM_DAT_O(MEM_DAT_O), .MEM_DAT_I(MEM_DAT_I),
    .MEM_RD_O(MEM_RD_O), .MEM_WR_O(MEM_WR_O), .MEM_ACK_I(MEM_ACK_I),
    .IO_PORT_O(IO_PORT_O), .IO_DAT_O(IO_DAT_O), .IO_DAT_I(IO_DAT_I),
    .IO_RD_O(IO_RD_O), .IO_WR_O(IO_WR_O), .IO_ACK_I(IO_ACK_I), .ERR_O(ERR_O)
  );

  always #5 CLK_I = ~CLK_I;

  always @(posedge MEM_RD_O) rd_rises++;
  always @(posedge ERR_O) err_rises++;
  always @(negedge CLK_I)
    if ($countones({MEM_RD_O, MEM_WR_O, IO_RD_O, IO_WR_O}) > 1) excl++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One CPU state: SYNC low for a cycle, then high with the state on the bus.
  task automatic step(input logic [2:0] st, input logic [7:0] dat);
    @(negedge CLK_I); SYNC_I = 1'b0;
    @(negedge CLK_I); SYNC_I = 1'b1; STATE_I = st; CPU_DAT_I = dat;
    @(posedge CLK_I); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nRST_I = 1'b0; SYNC_I = 1'b0; STATE_I = 3'b000; CPU_DAT_I = '0;
    INT_REQ_I = 1'b0; INT_VEC_I = '0; MEM_DAT_I = '0; MEM_ACK_I = 1'b0;
    IO_DAT_I = '0; IO_ACK_I = 1'b0;
    #22;
    check("rst_ready", READY_O, 1);
    check("rst_mem_rd", MEM_RD_O, 0);
    check("rst_cpu_dat", CPU_DAT_O, 0);
    check("rst_addr", MEM_ADDR_O, 0);
    check("rst_int", INT_O, 0);
    check("rst_err", ERR_O, 0);
    @(negedge CLK_I); nRST_I = 1'b1;

    // Memory read, PCI at 14'h1234
    step(T1, 8'h34);
    step(T2, 8'h12);
    check("rd_decode_ready", READY_O, 0);
    check("rd_addr", MEM_ADDR_O, 14'h1234);
    check("rd_decode_strobe", MEM_RD_O, 0);
    rd0 = rd_rises;
    MEM_DAT_I = 8'hC5;
    @(posedge CLK_I); #1;
    check("rd_strobe_up", MEM_RD_O, 1);
    repeat (2) @(posedge CLK_I); #1;
    check("rd_strobe_held", MEM_RD_O, 1);
    check("rd_ready_low", READY_O, 0);
    @(negedge CLK_I); MEM_ACK_I = 1'b1;
    @(posedge CLK_I); #1; MEM_ACK_I = 1'b0;
    check("rd_strobe_down", MEM_RD_O, 0);
    check("rd_ready_up", READY_O, 1);
    check("rd_data", CPU_DAT_O, 8'hC5);
    check("rd_pulses", rd_rises - rd0, 1);

    // Memory write, PCW at 14'h0100
    step(T1, 8'h00);
    step(T2, 8'hC1);
    check("wr_addr", MEM_ADDR_O, 14'h0100);
    step(T3, 8'h5A);
    check("wr_strobe", MEM_WR_O, 1);
    check("wr_data", MEM_DAT_O, 8'h5A);
    @(negedge CLK_I); MEM_ACK_I = 1'b1;
    @(posedge CLK_I); #1; MEM_ACK_I = 1'b0;
    check("wr_strobe_down", MEM_WR_O, 0);
    check("wr_ready", READY_O, 1);
    check("wr_cpu_dat_kept", CPU_DAT_O, 8'hC5);

    // OUT to port 15
    step(T1, 8'h77);
    step(T2, 8'h5E);
    @(posedge CLK_I); #1;
    check("out_strobe", IO_WR_O, 1);
    check("out_port", IO_PORT_O, 5'd15);
    check("out_data", IO_DAT_O, 8'h77);
    @(negedge CLK_I); IO_ACK_I = 1'b1;
    @(posedge CLK_I); #1; IO_ACK_I = 1'b0;
    check("out_strobe_down", IO_WR_O, 0);

    // INP from port 3, ack raised in the cycle the strobe rises
    step(T1, 8'h99);
    step(T2, 8'h46);
    IO_DAT_I = 8'hA7;
    @(posedge CLK_I); #1;
    check("inp_strobe", IO_RD_O, 1);
    check("inp_port", IO_PORT_O, 5'd3);
    IO_ACK_I = 1'b1;
    @(posedge CLK_I); #1; IO_ACK_I = 1'b0;
    check("inp_strobe_down", IO_RD_O, 0);
    check("inp_data", CPU_DAT_O, 8'hA7);
    check("inp_ready", READY_O, 1);

    // Interrupt acknowledge with jammed vector
    step(STOP, 8'h00);
    check("stop_ready", READY_O, 1);
    INT_VEC_I = 8'h0D; INT_REQ_I = 1'b1;
    @(posedge CLK_I); #1;
    check("int_set", INT_O, 1);
    INT_REQ_I = 1'b0;
    rd0 = rd_rises;
    step(T1I, 8'hAA);
    check("int_clear", INT_O, 0);
    step(T2, 8'h00);
    @(posedge CLK_I); #1;
    check("int_vec", CPU_DAT_O, 8'h0D);
    check("int_ready", READY_O, 1);
    check("int_no_rd", rd_rises - rd0, 0);
    check("int_still_low", INT_O, 0);

    // Timeout on a read with no acknowledge
    step(T1, 8'h10);
    step(T2, 8'h05);
    @(posedge CLK_I); #1;
    check("to_strobe", MEM_RD_O, 1);
    repeat (7) @(posedge CLK_I); #1;
    check("to_no_err_early", ERR_O, 0);
    check("to_strobe_held", MEM_RD_O, 1);
    @(posedge CLK_I); #1;
    check("to_err", ERR_O, 1);
    check("to_strobe_down", MEM_RD_O, 0);
    check("to_data", CPU_DAT_O, 8'hFF);
    check("to_ready", READY_O, 1);
    @(posedge CLK_I); #1;
    check("to_err_pulse", ERR_O, 0);
    check("to_err_count", err_rises, 1);

    // Acknowledge arriving on the expiry edge wins
    step(T1, 8'h11);
    step(T2, 8'h05);
    MEM_DAT_I = 8'h3C;
    @(posedge CLK_I); #1;
    repeat (7) @(posedge CLK_I); #1;
    MEM_ACK_I = 1'b1;
    @(posedge CLK_I); #1; MEM_ACK_I = 1'b0;
    check("race_no_err", ERR_O, 0);
    check("race_data", CPU_DAT_O, 8'h3C);
    check("race_err_count", err_rises, 1);

    // Reset asserted mid-access
    step(T1, 8'h20);
    step(T2, 8'h03);
    @(posedge CLK_I); #1;
    check("rst_acc_strobe", MEM_RD_O, 1);
    @(negedge CLK_I); #2; nRST_I = 1'b0; #1;
    check("rst_async_drop", MEM_RD_O, 0);
    check("rst_async_ready", READY_O, 1);
    @(negedge CLK_I); nRST_I = 1'b1;
    @(posedge CLK_I); #1;
    check("rst_cpu_dat_clr", CPU_DAT_O, 0);
    step(T1, 8'hAB);
    step(T2, 8'h8F);
    check("post_rst_addr", MEM_ADDR_O, 14'h0FAB);
    MEM_DAT_I = 8'h66;
    @(posedge CLK_I); #1;
    check("post_rst_strobe", MEM_RD_O, 1);
    @(negedge CLK_I); MEM_ACK_I = 1'b1;
    @(posedge CLK_I); #1; MEM_ACK_I = 1'b0;
    check("post_rst_data", CPU_DAT_O, 8'h66);

    check("strobe_exclusive", excl, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mcs8_bus_ctrl.md
MCS8_BUS_CTRL -- requirements
Module: mcs8_bus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum CLK_I cycles an access waits for acknowledge.
REQ-002 SHALL have ports:
- CLK_I  in  1  single system clock; all logic on rising edge.
- nRST_I  in  1  reset, asynchronous, active-low.
- SYNC_I  in  1  CPU SYNC; one CPU state per SYNC period.
- STATE_I  in  3  CPU state code: T1=010, T2=100, T3=001, T4=111, T5=101, T1I=110, STOP=011, WAIT=000.
- CPU_DAT_I  in  8  CPU bus output.
- CPU_DAT_O  out  8  data to CPU.
- READY_O  out  1  CPU READY.
- INT_REQ_I  in  1  external interrupt request, level.
- INT_VEC_I  in  8  instruction jammed during interrupt acknowledge.
- INT_O  out  1  CPU INT.
- MEM_ADDR_O  out  14  memory address.
- MEM_DAT_O  out  8  memory write data.
- MEM_DAT_I  in  8  memory read data.
- MEM_RD_O  out  1  memory read strobe.
- MEM_WR_O  out  1  memory write strobe.
- MEM_ACK_I  in  1  memory acknowledge.
- IO_PORT_O  out  5  I/O port number.
- IO_DAT_O  out  8  output-port data.
- IO_DAT_I  in  8  input-port data.
- IO_RD_O  out  1  input strobe.
- IO_WR_O  out  1  output strobe.
- IO_ACK_I  in  1  I/O acknowledge.
- ERR_O  out  1  one-cycle timeout pulse.

Function
REQ-003 SHALL generate a state strobe on the CLK_I edge where SYNC_I is 1 and was 0 on the previous edge; STATE_I and CPU_DAT_I SHALL be sampled only on strobes.
REQ-004 SHALL implement FSM IDLE, ADDR_L, DECODE, WAIT_T3, ACCESS, HOLD.
REQ-005 IDLE: on a T1 or T1I strobe, latch CPU_DAT_I as address low byte and go to ADDR_L; a T1I strobe also sets the ack flag.
REQ-006 ADDR_L: on a T2 strobe, latch CPU_DAT_I[5:0] as address high, latch CPU_DAT_I[7:6] as cycle type (PCI=00, PCC=01, PCR=10, PCW=11), drop READY_O, and go to DECODE.
REQ-007 DECODE, one cycle:
- PCI/PCR with ack flag set: load CPU_DAT_O with INT_VEC_I, raise READY_O, go to HOLD; no memory strobe.
- PCI/PCR otherwise: assert MEM_RD_O, go to ACCESS.
- PCW: go to WAIT_T3.
- PCC with address high [5:4]==00: input cycle; IO_PORT_O gets addr_h[5:1]; assert IO_RD_O; go to ACCESS.
- PCC otherwise: output cycle; IO_DAT_O gets the latched low byte; assert IO_WR_O; go to ACCESS.
REQ-008 WAIT_T3: on a T3 or WAIT strobe, latch CPU_DAT_I into MEM_DAT_O, assert MEM_WR_O, and go to ACCESS.
REQ-009 ACCESS: keep the strobe high until the selected ACK is 1. On ACK:
- Drop the strobe.
- Read cycles load CPU_DAT_O from MEM_DAT_I or IO_DAT_I.
- Raise READY_O and go to HOLD.
REQ-010 While in ACCESS, a counter SHALL increment each cycle. When it reaches TIMEOUT:
- Drop the strobe.
- Read cycles load CPU_DAT_O with 8'hFF.
- Pulse ERR_O for 1 cycle, raise READY_O, and go to HOLD.
REQ-011 HOLD: CPU_DAT_O SHALL remain stable. On the next T1/T1I strobe, clear the ack flag and act as IDLE (REQ-005). On a STOP strobe, go to IDLE.
REQ-012 A STOP strobe in any state SHALL drop all strobes, raise READY_O, and go to IDLE.
REQ-013 MEM_ADDR_O SHALL equal {addr_h, addr_l} from the DECODE cycle until the next T2 latch.
REQ-014 MEM_RD_O, MEM_WR_O, IO_RD_O and IO_WR_O SHALL be mutually exclusive.
REQ-015 Strobe-to-ACK latency SHALL be at least 1 cycle; an ACK arriving in the same cycle the strobe rises SHALL be accepted on the next edge.
REQ-016 INT_O SHALL set when INT_REQ_I=1 in IDLE or HOLD, and SHALL clear on a T1I strobe; INT_REQ_I in other states SHALL be held pending.
REQ-017 A TIMEOUT ack and a counter expiry on the same edge SHALL be treated as ACK, with no ERR_O.

Reset
REQ-018 While nRST_I=0, the block SHALL:
- Hold the FSM in IDLE.
- Hold READY_O=1 and all other outputs at 0.
- Clear counter, flags and latches.
REQ-019 Reset asserted mid-access SHALL drop strobes immediately, without waiting for a clock edge.

Structure
REQ-020 The state encodings, cycle-type encodings and FSM state enum SHALL live in a shared package mcs8_pkg, also used by cpu_state.
REQ-021 The timeout counter SHALL be a sub-module mcs8_bus_timer, with clear, enable and expired signals.

Verification
REQ-022 Memory read, PCI: T1 bus 8'h34, T2 bus 8'h12 (type 00), MEM_ACK after 3 cycles, MEM_DAT_I=8'hC5 -> MEM_ADDR_O=14'h1234, 1 MEM_RD_O pulse, READY_O low until ACK, CPU_DAT_O=8'hC5.
REQ-023 Memory write, PCW: T1 bus 8'h00, T2 bus 8'hC1, T3 bus 8'h5A -> MEM_ADDR_O=14'h0100, MEM_WR_O with MEM_DAT_O=8'h5A.
REQ-024 OUT: T1 bus 8'h77, T2 bus 8'h5E (PCC, port 15) -> IO_WR_O, IO_PORT_O=5'd15, IO_DAT_O=8'h77. INP: T2 bus 8'h46 -> IO_RD_O, IO_PORT_O=5'd3.
REQ-025 Interrupt: INT_REQ_I=1 in IDLE, INT_VEC_I=8'h0D -> INT_O=1; T1I, then T2 type 00 -> CPU_DAT_O=8'h0D, no MEM_RD_O, INT_O=0.
REQ-026 Timeout: TIMEOUT=8, no ACK -> ERR_O pulses once 8 cycles after MEM_RD_O rises, CPU_DAT_O=8'hFF, READY_O=1.
REQ-027 Reset during ACCESS -> MEM_RD_O falls asynchronously; FSM returns to IDLE and READY_O=1.
